// File: rtl/mem_arb_pkg.sv
// ============================================================================
// mem_arb_pkg : shared types and constants for the two-port memory arbiter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } arb_state_e;

  localparam bit PORT_IFU = 1'b0;
  localparam bit PORT_LSU = 1'b1;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned LEN_W  = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned CNT_W  = 8;

  typedef struct packed {
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  function automatic logic [1:0] port_onehot(input logic port);
    return (port == PORT_IFU) ? 2'b01 : 2'b10;
  endfunction

endpackage : mem_arb_pkg

`default_nettype wire

// File: rtl/rr_pick2.sv
// ============================================================================
// rr_pick2 : combinational two-way round-robin pick with one-hot grant
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  // On a tie the port that did not win last time is favoured.
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule : rr_pick2

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : round-robin IFU/LSU arbiter and sequencer for one memory port
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic              req_wen0,
  input  logic              req_wen1,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [LEN_W-1:0]  req_len0,
  input  logic [LEN_W-1:0]  req_len1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_wout,
  output logic              mem_addr_valid,
  output logic              mem_data_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LEN_W-1:0]  mem_len,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ready,
  input  logic              mem_data_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e        state_q;
  cmd_t              cmd_q;
  cmd_t              cmd_d;
  logic              owner_q;
  logic              last_grant_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic [1:0]        w_grant;
  logic              w_idle;
  logic              w_issue;
  logic              w_resp;

  rr_pick2 u_pick (
    .req_i  (req_valid),
    .last_i (last_grant_q),
    .gnt_o  (w_grant)
  );

  assign w_idle  = (state_q == IDLE);
  assign w_issue = (state_q == ISSUE);
  assign w_resp  = (state_q == RESP);

  assign req_ready = w_idle ? w_grant : 2'b00;

  always_comb begin
    cmd_d = '0;
    if (w_grant[PORT_LSU]) begin
      cmd_d.wen   = req_wen1;
      cmd_d.addr  = req_addr1;
      cmd_d.len   = req_len1;
      cmd_d.wdata = req_wdata1;
    end else begin
      cmd_d.wen   = req_wen0;
      cmd_d.addr  = req_addr0;
      cmd_d.len   = req_len0;
      cmd_d.wdata = req_wdata0;
    end
  end

  // Memory side is only driven while issuing, so an async reset drops it at once.
  assign mem_en         = w_issue;
  assign mem_addr_valid = w_issue;
  assign mem_wout       = w_issue & cmd_q.wen;
  assign mem_data_ready = w_issue & cmd_q.wen;
  assign mem_addr       = w_issue ? cmd_q.addr  : '0;
  assign mem_len        = w_issue ? cmd_q.len   : '0;
  assign mem_wdata      = w_issue ? cmd_q.wdata : '0;

  assign rsp_valid = w_resp ? port_onehot(owner_q) : 2'b00;
  assign rsp_rdata = w_resp ? rdata_q : '0;
  assign rsp_err   = w_resp & err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      owner_q      <= PORT_IFU;
      last_grant_q <= PORT_LSU;
      cnt_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            cmd_q   <= cmd_d;
            owner_q <= w_grant[PORT_LSU];
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_addr_ready) begin
            if (cmd_q.wen) begin
              rdata_q <= '0;
              err_q   <= 1'b0;
              state_q <= RESP;
            end else begin
              cnt_q   <= '0;
              state_q <= WAIT_RD;
            end
          end
        end
        WAIT_RD: begin
          if (mem_data_valid) begin
            rdata_q <= mem_rdata;
            err_q   <= 1'b0;
            state_q <= RESP;
          end else if (cnt_q == c_CNT_LAST) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          last_grant_q <= owner_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule : mem_arbiter

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : directed self-checking bench for mem_arbiter
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic        t_wen   [2];
  logic [63:0] t_addr  [2];
  logic [31:0] t_len   [2];
  logic [63:0] t_wdata [2];
  logic [1:0]  rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_en, mem_wout, mem_addr_valid, mem_data_ready;
  logic [63:0] mem_addr;
  logic [31:0] mem_len;
  logic [63:0] mem_wdata;
  logic        mem_addr_ready, mem_data_valid;
  logic [63:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(TMO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_wen0       (t_wen[0]),
    .req_wen1       (t_wen[1]),
    .req_addr0      (t_addr[0]),
    .req_addr1      (t_addr[1]),
    .req_len0       (t_len[0]),
    .req_len1       (t_len[1]),
    .req_wdata0     (t_wdata[0]),
    .req_wdata1     (t_wdata[1]),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .mem_en         (mem_en),
    .mem_wout       (mem_wout),
    .mem_addr_valid (mem_addr_valid),
    .mem_data_ready (mem_data_ready),
    .mem_addr       (mem_addr),
    .mem_len        (mem_len),
    .mem_wdata      (mem_wdata),
    .mem_addr_ready (mem_addr_ready),
    .mem_data_valid (mem_data_valid),
    .mem_rdata      (mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full transaction starting at a negedge in IDLE. adly = cycles mem_addr_ready
  // stays low in ISSUE; ddly = WAIT_RD cycles before data (-1 = never, expect timeout).
  task automatic txn(input logic [1:0] mask, input int p, input int adly,
                     input int ddly, input logic [63:0] mdata);
    logic [1:0]  oh;
    logic [63:0] exp_rd;
    logic        exp_err;
    int          waits;
    oh = (p == 0) ? 2'b01 : 2'b10;
    req_valid = mask;
    #1;
    check("req_ready", req_ready, oh);
    tick();
    for (int i = 0; i <= adly; i++) begin
      check("issue_ctl", {mem_en, mem_addr_valid}, 2'b11);
      check("issue_addr", mem_addr, t_addr[p]);
      check("issue_len", mem_len, t_len[p]);
      check("issue_wr", {mem_wout, mem_data_ready}, {t_wen[p], t_wen[p]});
      if (t_wen[p]) check("issue_wdata", mem_wdata, t_wdata[p]);
      check("busy_ready", req_ready, 2'b00);
      check("early_rsp", rsp_valid, 2'b00);
      mem_addr_ready = (i == adly);
      tick();
    end
    mem_addr_ready = 1'b0;
    if (!t_wen[p]) begin
      waits = (ddly < 0) ? TMO : ddly;
      for (int j = 0; j < waits; j++) begin
        check("wait_ctl", {mem_en, mem_addr_valid, mem_wout, mem_data_ready}, 4'b0000);
        check("wait_rsp", rsp_valid, 2'b00);
        tick();
      end
      if (ddly >= 0) begin
        check("wait_ctl", {mem_en, mem_addr_valid}, 2'b00);
        mem_data_valid = 1'b1;
        mem_rdata      = mdata;
        tick();
        mem_data_valid = 1'b0;
        mem_rdata      = '0;
      end
    end
    exp_err = !t_wen[p] && (ddly < 0);
    exp_rd  = (!t_wen[p] && ddly >= 0) ? mdata : 64'h0;
    check("rsp_valid", rsp_valid, oh);
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("rsp_err", rsp_err, exp_err);
    check("rsp_memen", mem_en, 1'b0);
    tick();
    check("rsp_pulse", rsp_valid, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b00;
    mem_addr_ready = 1'b0;
    mem_data_valid = 1'b0;
    mem_rdata = '0;
    for (int k = 0; k < 2; k++) begin
      t_wen[k] = 1'b0; t_addr[k] = '0; t_len[k] = '0; t_wdata[k] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", req_ready, 2'b00);
    check("rst_rsp", {rsp_valid, rsp_err}, 3'b000);
    check("rst_rdata", rsp_rdata, 64'h0);
    check("rst_mem", {mem_en, mem_wout, mem_addr_valid, mem_data_ready}, 4'b0000);
    check("rst_addr", mem_addr, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // IFU read, single-cycle memory
    t_wen[0] = 1'b0; t_addr[0] = 64'h8000_0000; t_len[0] = 32'd8;
    txn(2'b01, 0, 0, 0, 64'hDEAD_BEEF_0000_0013);
    req_valid = 2'b00;

    // LSU write with three stalled ISSUE cycles
    t_wen[1] = 1'b1; t_addr[1] = 64'h8000_0100; t_len[1] = 32'd4; t_wdata[1] = 64'h1234;
    txn(2'b10, 1, 3, 0, 64'h0);
    req_valid = 2'b00;

    // reads of every narrow size, one extra memory delay cycle
    t_wen[1] = 1'b0; t_addr[1] = 64'h8000_0201; t_len[1] = 32'd1;
    txn(2'b10, 1, 0, 1, 64'h0000_0000_0000_00A5);
    t_addr[1] = 64'h8000_0202; t_len[1] = 32'd2;
    txn(2'b10, 1, 0, 1, 64'hFFFF_0000_0000_BEEF);
    t_addr[1] = 64'h8000_0204; t_len[1] = 32'd4;
    txn(2'b10, 1, 0, 1, 64'h1122_3344_5566_7788);
    req_valid = 2'b00;

    // read timeout, then a stray data-valid in IDLE
    t_addr[0] = 64'h8000_0300; t_len[0] = 32'd8;
    txn(2'b01, 0, 0, -1, 64'h0);
    req_valid = 2'b00;
    mem_data_valid = 1'b1;
    mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    mem_data_valid = 1'b0;
    mem_rdata = '0;
    check("stray_rsp", rsp_valid, 2'b00);
    check("stray_mem", mem_en, 1'b0);
    tick();
    check("stray_rsp2", rsp_valid, 2'b00);

    // both ports valid back-to-back from reset: alternation
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    t_wen[0] = 1'b0; t_addr[0] = 64'h8000_1000; t_len[0] = 32'd4;
    t_wen[1] = 1'b1; t_addr[1] = 64'h8000_2000; t_len[1] = 32'd8; t_wdata[1] = 64'hCAFE;
    for (int i = 0; i < 8; i++) txn(2'b11, i % 2, 0, 0, 64'hA000 + 64'(i));
    req_valid = 2'b00;

    // reset while issuing drops memory controls without a clock
    t_wen[1] = 1'b0; t_addr[1] = 64'h8000_0400; t_len[1] = 32'd8;
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    check("abort_issue_en", mem_en, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_issue_drop", {mem_en, mem_addr_valid}, 2'b00);
    check("abort_issue_addr", mem_addr, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_issue_rsp", rsp_valid, 2'b00);

    // IFU last, then reset in WAIT_RD must restore port-0 tie priority
    t_wen[0] = 1'b0; t_addr[0] = 64'h8000_0040; t_len[0] = 32'd4;
    txn(2'b01, 0, 0, 0, 64'h55);
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    mem_addr_ready = 1'b1;
    tick();
    mem_addr_ready = 1'b0;
    rst_n = 1'b0;
    mem_data_valid = 1'b1;
    mem_rdata = 64'h99;
    #1;
    check("abort_wait_out", {rsp_valid, rsp_err, mem_en, req_ready}, 6'b0);
    check("abort_wait_rdata", rsp_rdata, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mem_data_valid = 1'b0;
    mem_rdata = '0;
    for (int k = 0; k < 2; k++) begin
      check("abort_wait_rsp", rsp_valid, 2'b00);
      tick();
    end
    t_wen[1] = 1'b1; t_addr[1] = 64'h8000_0500; t_len[1] = 32'd2; t_wdata[1] = 64'h77;
    txn(2'b11, 0, 0, 0, 64'h0BAD_F00D);
    req_valid = 2'b00;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mem_arbiter

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

- Two-port round-robin arbiter and sequencer sitting in front of the single DPI memory port.
- Port 0 is instruction fetch; port 1 is load/store.
- Grants one requester at a time, drives the memory address/data handshake, and routes read data or write completion back to the owner.
- A read-response watchdog flags an error if memory never answers.

## Interface
Parameters:
- TIMEOUT, 16, cycles to wait in WAIT_RD for mem_data_valid before an error response; legal range 2..255.

Ports (clock and reset first; reset is asynchronous, active-low):
- clk  in  1  core clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-port request valid; bit 0 is IFU, bit 1 is LSU.
- req_ready  out  2  per-port request accept; one-hot or zero.
- req_wen0/req_wen1  in  1  write request.
- req_addr0/req_addr1  in  64  byte address.
- req_len0/req_len1  in  32  access size in bytes; legal values 1, 2, 4, 8.
- req_wdata0/req_wdata1  in  64  store data.
- rsp_valid  out  2  per-port response pulse, one cycle; no back-pressure.
- rsp_rdata  out  64  read data; 0 for writes and errors.
- rsp_err  out  1  qualifies rsp_valid; timeout occurred.
- mem_en, mem_wout, mem_addr_valid, mem_data_ready  out  1  memory request controls.
- mem_addr  out  64  memory address.
- mem_len  out  32  memory access size.
- mem_wdata  out  64  memory write data.
- mem_addr_ready, mem_data_valid  in  1  memory handshake inputs.
- mem_rdata  in  64  memory read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RD, RESP.
- **IDLE**
  - If any req_valid is set, pick a winner. A single requester always wins. On a tie, the port not equal to last_grant wins.
  - Assert req_ready[winner] combinationally in that cycle.
  - On the edge: capture wen/addr/len/wdata into the cmd register, set owner, go ISSUE.
- **ISSUE**
  - Drive mem_en=1, mem_addr_valid=1, mem_wout=cmd.wen, mem_data_ready=cmd.wen, plus address, len and wdata from the cmd register.
  - No mem_addr_ready: hold all outputs.
  - mem_addr_ready with a write: go RESP with rdata=0, err=0.
  - mem_addr_ready with a read: clear the timeout counter, go WAIT_RD.
- **WAIT_RD**
  - All mem_* controls are 0; mem_en must drop after accept.
  - mem_data_valid: capture mem_rdata, go RESP with err=0.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without data valid, go RESP with rdata=0, err=1.
- **RESP**
  - Assert rsp_valid[owner] with the captured rdata/err.
  - Set last_grant=owner, go IDLE.
- General rules:
  - mem_data_valid outside WAIT_RD is ignored.
  - req_len is forwarded unchanged; illegal sizes are not checked.
  - req_ready is never asserted outside IDLE.
  - Requester inputs are don't-care after the handshake.

## Timing
- Reset values:
  - state=IDLE, last_grant=1, so port 0 wins the first tie.
  - All outputs 0; cmd, counter, rdata and err registers 0.
  - Reset mid-transaction aborts silently: no rsp_valid, memory controls drop immediately.
- Read latency, with request handshake at cycle T and memory accepting in ISSUE:
  - ISSUE at T+1.
  - mem_data_valid at T+2 with the single-cycle memory.
  - rsp_valid at T+3.
  - Each extra memory delay cycle adds one.
- Write latency: ISSUE at T+1, rsp_valid at T+2.
- Back-to-back: the next grant can occur in the cycle after RESP. Minimum request spacing per port is 4 cycles for reads and 3 for writes.
- Timeout response: rsp_valid exactly TIMEOUT+1 cycles after the ISSUE accept edge.

## Structure
- Package mem_arb_pkg holds:
  - state enum arb_state_e.
  - PORT_IFU=0 and PORT_LSU=1.
  - The cmd_t struct: wen, addr, len, wdata.
- One sub-module, rr_pick2: combinational 2-way round-robin pick taking req[1:0] and last, producing a one-hot grant.
- Datapath muxing and the FSM stay in mem_arbiter.

## Test plan
- Single IFU read of 0x8000_0000, len 8, memory returns 0xDEADBEEF_00000013 one cycle after accept -> rsp_valid[0] at T+3 with that data, rsp_err=0.
- LSU write to 0x8000_0100, len 4, wdata 0x1234, mem_addr_ready held low 3 cycles -> ISSUE held stable for 3 cycles; after accept, mem_wout=1 and mem_data_ready=1; rsp_valid[1] one cycle later.
- Both ports valid continuously after reset -> grants alternate 0,1,0,1; no starvation over 8 transactions.
- Read with memory never asserting mem_data_valid, TIMEOUT=16 -> rsp_valid with rsp_err=1 and rsp_rdata=0 at accept+17; a stray later mem_data_valid in IDLE is ignored.
- rst_n asserted during WAIT_RD -> all outputs 0 immediately; no rsp_valid; the first post-reset tie goes to port 0.
- Reads with len 1, 2 and 4 -> mem_len matches each request; rsp_rdata passes mem_rdata unmodified.
